// File: rtl/lsu_pkg.sv
// Shared types and sizing for the load/store controller and its address generator.
// Holds the FSM state encoding, memory geometry and the latched request format.
package lsu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/lsu_agen.sv
// Effective-address generator: base + sign-extended offset; combinational, no backpressure.
// LSU_BOUNDS_CHECK_EN selects fault-on-out-of-range instead of wrapping modulo DEPTH.
module lsu_agen
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] base_i,
   input  logic [ADDR_W-1:0] offset_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              fault_o
);

   logic [DATA_W-1:0] ea_full;

   // Carry out of the DATA_W-bit sum is dropped, so negative results land high.
   assign ea_full = base_i + {{(DATA_W-ADDR_W){offset_i[ADDR_W-1]}}, offset_i};

`ifdef LSU_BOUNDS_CHECK_EN
   assign fault_o = (ea_full >= DATA_W'(DEPTH));
   assign addr_o  = ea_full[ADDR_W-1:0];
`else
   assign fault_o = 1'b0;
   assign addr_o  = ADDR_W'(ea_full % DATA_W'(DEPTH));
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for the 32x16 data memory; optional LSU_BOUNDS_CHECK_EN fault detection.
// One request in flight, response 2 cycles after acceptance; response held until rsp_ready.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [DATA_W-1:0] req_base,
   input  logic [ADDR_W-1:0] req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   lsu_state_e        state_q;
   lsu_req_t          req_q;
   logic              fault_q;
   logic              req_ready_q;
   logic              mem_read_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;
   logic              busy_q;

   logic [ADDR_W-1:0] agen_addr;
   logic              agen_fault;

   lsu_agen u_agen (
      .base_i   (req_base),
      .offset_i (req_offset),
      .addr_o   (agen_addr),
      .fault_o  (agen_fault)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= '0;
         fault_q     <= 1'b0;
         req_ready_q <= 1'b1;
         mem_read_q  <= 1'b1;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_q       <= '{we: req_we, ea: agen_addr, wdata: req_wdata};
                  fault_q     <= agen_fault;
                  // Write strobe is set up here so it is registered for the ACCESS cycle.
                  mem_read_q  <= !(req_we && !agen_fault);
                  if (req_we) begin
                     mem_wdata_q <= req_wdata;
                  end
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               mem_read_q  <= 1'b1;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= fault_q;
               rsp_data_q  <= fault_q ? '0 : (req_q.we ? req_q.wdata : mem_rdata);
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign mem_addr  = req_q.ea;
   assign mem_read  = mem_read_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed cases, backpressure, reset mid-store, random traffic.
// Expected responses come from an arithmetic model of the address rules and a shadow memory.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_we;
   logic [DATA_W-1:0] req_base, req_wdata;
   logic [ADDR_W-1:0] req_offset;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              rsp_valid, rsp_ready, rsp_err, busy;
   logic [DATA_W-1:0] rsp_data;

   always #5 clk = ~clk;

`ifdef LSU_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              mon_e;
   int                n_tests = 0;
   int                n_fail  = 0;
   logic [DATA_W-1:0] mem     [0:DEPTH-1];
   logic [DATA_W-1:0] ref_mem [0:DEPTH-1];

   lsu_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_base   (req_base),
      .req_offset (req_offset),
      .req_wdata  (req_wdata),
      .mem_addr   (mem_addr),
      .mem_read   (mem_read),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Data memory: combinational read, write on the rising edge while mem_read is low.
   assign mem_rdata = mem[mem_addr[4:0]];

   always @(posedge clk) begin
      if (mem_read === 1'b0) begin
         if (mem_addr >= 6'd32) begin
            n_tests++;
            n_fail++;
            $display("FAIL oob_write: addr=%0d (must be < %0d)", mem_addr, DEPTH);
         end else begin
            mem[mem_addr[4:0]] = mem_wdata;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every response handshake pops and checks one expected entry.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_rsp: data=0x%0h err=%0b with no request outstanding", rsp_data, rsp_err);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
         end
      end
   end

   // Reference: integer arithmetic on the address rules plus a shadow memory.
   task automatic model(input logic we, input logic [DATA_W-1:0] base, input logic [ADDR_W-1:0] off,
                        input logic [DATA_W-1:0] wd, output int exp_addr, output logic exp_rd,
                        output exp_t e);
      int ea;
      int so;
      bit fault;
      so = off[5] ? int'(off) - 64 : int'(off);
      ea = int'(base) + so;
      if (ea < 0) ea += 65536;
      if (ea >= 65536) ea -= 65536;
      fault    = BOUNDS && (ea >= DEPTH);
      exp_addr = fault ? ea % 64 : ea % DEPTH;
      exp_rd   = !(we && !fault);
      if (fault) begin
         e = '{data: '0, err: 1'b1};
      end else if (we) begin
         ref_mem[exp_addr] = wd;
         e = '{data: wd, err: 1'b0};
      end else begin
         e = '{data: ref_mem[exp_addr], err: 1'b0};
      end
      exp_q.push_back(e);
   endtask

   // Issue one request; with stall>0, hold rsp_ready low and flood a ghost store meanwhile.
   task automatic issue(input logic we, input logic [DATA_W-1:0] base, input logic [ADDR_W-1:0] off,
                        input logic [DATA_W-1:0] wd, input int stall);
      int   exp_addr;
      logic exp_rd;
      exp_t e;
      int   t;
      @(posedge clk);
      #2;
      req_valid  = 1'b1;
      req_we     = we;
      req_base   = base;
      req_offset = off;
      req_wdata  = wd;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: req_ready=%0b, expected 1 within 20 cycles", req_ready);
         req_valid = 1'b0;
         return;
      end
      model(we, base, off, wd, exp_addr, exp_rd, e);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      rsp_ready = (stall == 0);
      @(negedge clk);
      chk("access_addr", 32'(mem_addr), 32'(exp_addr));
      chk("access_read", 32'(mem_read), 32'(exp_rd));
      chk("access_no_rsp", 32'(rsp_valid), 32'd0);
      chk("access_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_read", 32'(mem_read), 32'd1);
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      if (stall > 0) begin
         for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #2;
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_base   = 16'($urandom_range(0, DEPTH-1));
            req_offset = '0;
            req_wdata  = 16'hDEAD;
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(e.data));
            chk("hold_err", 32'(rsp_err), 32'(e.err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
         end
         @(posedge clk);
         #2;
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_n      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_base   = '0;
      req_offset = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 16'(i);
         ref_mem[i] = 16'(i);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_mem_read", 32'(mem_read), 32'd1);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_data", 32'(rsp_data), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      issue(1'b0, 16'd5, 6'd3, 16'h0, 0);
      issue(1'b1, 16'd10, 6'd0, 16'hBEEF, 0);
      issue(1'b0, 16'd10, 6'd0, 16'h0, 0);
      issue(1'b0, 16'd4, 6'b111010, 16'h0, 0);
      issue(1'b1, 16'd31, 6'd1, 16'h1234, 0);
      issue(1'b0, 16'd0, 6'd0, 16'h0, 0);
      issue(1'b0, 16'd2, 6'd1, 16'h0, 4);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
      end
      chk("drop_mem", 32'(mem[7]), 32'(ref_mem[7]));

      // Reset during the ACCESS cycle of a store to address 3.
      @(posedge clk);
      #2;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_base   = 16'd3;
      req_offset = '0;
      req_wdata  = 16'hAAAA;
      @(negedge clk);
      chk("rst_pre_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      chk("rst_store_strobe", 32'(mem_read), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mem_read", 32'(mem_read), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_resume", 32'(busy | rsp_valid), 32'd0);
      end
      chk("rst_mem3", 32'(mem[3]), 32'd3);

      for (int n = 0; n < 60; n++) begin
         logic              we;
         logic [DATA_W-1:0] base;
         we   = 1'($urandom_range(0, 1));
         base = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
         issue(we, base, 6'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
